// File: rtl/target_pkg.sv
// Shared types and constants for the laser/photo-target round controller.
package target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    ACTIVE,
    END,
    GAME_OVER
  } state_e;

  typedef logic [15:0] bcd_t;

  localparam logic [3:0] NO_TARGET = 4'd15;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsrStep(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score register: synchronous add of 0, 1 or 2, saturating at 9999.
module bcd_counter4
  import target_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic [1:0] add_i,
  output bcd_t       count_o
);

  bcd_t       count_q;
  bcd_t       count_d;
  logic       saturate;
  logic [1:0] carry;
  logic [4:0] digitSum;
  logic [4:0] digitWrap;

  // Any add that would pass 9999 pins the score there instead of wrapping.
  assign saturate = (count_q == 16'h9999) ||
                    ((count_q == 16'h9998) && (add_i >= 2'd2));

  always_comb begin
    count_d   = count_q;
    carry     = add_i;
    digitSum  = '0;
    digitWrap = '0;
    if (clear_i) begin
      count_d = '0;
    end else if (saturate) begin
      count_d = 16'h9999;
    end else begin
      for (int i = 0; i < 4; i++) begin
        digitSum  = {1'b0, count_q[i*4 +: 4]} + {3'b000, carry};
        digitWrap = digitSum - 5'd10;
        if (digitSum > 5'd9) begin
          count_d[i*4 +: 4] = digitWrap[3:0];
          carry             = 2'd1;
        end else begin
          count_d[i*4 +: 4] = digitSum[3:0];
          carry             = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/target_sequencer.sv
// Game-round controller: picks two lit targets per round, fires lasers on flex gestures,
// debounces photo hits on the lit targets and keeps the BCD score and round count.
module target_sequencer
  import target_pkg::*;
#(
  parameter int         NUM_TARGETS     = 10,
  parameter int         ROUNDS          = 20,
  parameter int         ROUND_CYCLES    = 50000000,
  parameter int         LASER_CYCLES    = 5000000,
  parameter int         DEBOUNCE_CYCLES = 1000,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   flex_l,
  input  logic                   flex_r,
  input  logic [NUM_TARGETS-1:0] photo_array,
  output logic                   laser_l,
  output logic                   laser_r,
  output logic [3:0]             target_a,
  output logic [3:0]             target_b,
  output bcd_t                   score_bcd,
  output logic [7:0]             round_num,
  output logic                   game_over
);

  localparam int TIMER_W = $clog2(ROUND_CYCLES + 1);
  localparam int LASER_W = $clog2(LASER_CYCLES + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(ROUND_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [LASER_W-1:0] LASER_LOAD   = LASER_W'(LASER_CYCLES);
  localparam logic [LASER_W-1:0] LASER_ONE    = LASER_W'(1);
  localparam logic [DEB_W-1:0]   DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_ONE      = DEB_W'(1);
  localparam logic [4:0]         TARGET_LIMIT = 5'(NUM_TARGETS);
  localparam logic [7:0]         LAST_ROUND   = 8'(ROUNDS - 1);

  state_e state_q, state_d;

  logic [1:0]             flexMeta_q, flexSync_q, flexPrev_q;
  logic [NUM_TARGETS-1:0] photoMeta_q, photoSync_q;

  logic [7:0]         lfsr_q, lfsr_d;
  logic [3:0]         aSel_q, aSel_d, bSel_q, bSel_d;
  logic               haveA_q, haveA_d;
  logic               hitA_q, hitA_d, hitB_q, hitB_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         round_q, round_d;
  logic [LASER_W-1:0] laserLCnt_q, laserLCnt_d, laserRCnt_q, laserRCnt_d;
  logic [DEB_W-1:0]   debA_q, debA_d, debB_q, debB_d;

  logic [1:0] flexRise;
  logic       photoA, photoB;
  logic       inActive, laserOn;
  logic       aArmed, bArmed, hitANow, hitBNow;
  logic [3:0] candidate;
  logic       candValid;
  logic       scoreClear;
  logic [1:0] scoreAdd;

  // Two-flop synchronisers; the extra flex flop gives a clean rising-edge detect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flexMeta_q  <= '0;
      flexSync_q  <= '0;
      flexPrev_q  <= '0;
      photoMeta_q <= '0;
      photoSync_q <= '0;
    end else begin
      flexMeta_q  <= {flex_r, flex_l};
      flexSync_q  <= flexMeta_q;
      flexPrev_q  <= flexSync_q;
      photoMeta_q <= photo_array;
      photoSync_q <= photoMeta_q;
    end
  end

  assign flexRise = flexSync_q & ~flexPrev_q;

  always_comb begin
    photoA = 1'b0;
    photoB = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (aSel_q == 4'(i)) photoA = photoSync_q[i];
      if (bSel_q == 4'(i)) photoB = photoSync_q[i];
    end
  end

  assign inActive = (state_q == ACTIVE);
  assign laserOn  = inActive && ((laserLCnt_q != '0) || (laserRCnt_q != '0));
  assign aArmed   = inActive && !hitA_q && laserOn && photoA;
  assign bArmed   = inActive && !hitB_q && laserOn && photoB;
  assign hitANow  = aArmed && (debA_q == DEB_LAST);
  assign hitBNow  = bArmed && (debB_q == DEB_LAST);
  assign scoreAdd = {1'b0, hitANow} + {1'b0, hitBNow};

  assign candidate = lfsr_q[3:0];
  assign candValid = ({1'b0, candidate} < TARGET_LIMIT);
  assign lfsr_d    = (state_q == PICK) ? lfsrStep(lfsr_q) : lfsr_q;

  // Debounce runs only while the target is open, lit by a laser and its photo bit stays high.
  always_comb begin
    debA_d = '0;
    debB_d = '0;
    if (aArmed && (debA_q != DEB_LAST)) debA_d = debA_q + DEB_ONE;
    if (bArmed && (debB_q != DEB_LAST)) debB_d = debB_q + DEB_ONE;
  end

  always_comb begin
    laserLCnt_d = '0;
    laserRCnt_d = '0;
    if (inActive) begin
      if (flexRise[0]) begin
        laserLCnt_d = LASER_LOAD;
      end else if (laserLCnt_q != '0) begin
        laserLCnt_d = laserLCnt_q - LASER_ONE;
      end
      if (flexRise[1]) begin
        laserRCnt_d = LASER_LOAD;
      end else if (laserRCnt_q != '0) begin
        laserRCnt_d = laserRCnt_q - LASER_ONE;
      end
    end
  end

  // A hit and a timeout in the same cycle both land: the score adds while the FSM leaves.
  always_comb begin
    state_d    = state_q;
    aSel_d     = aSel_q;
    bSel_d     = bSel_q;
    haveA_d    = haveA_q;
    hitA_d     = hitA_q;
    hitB_d     = hitB_q;
    timer_d    = timer_q;
    round_d    = round_q;
    scoreClear = 1'b0;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_d    = PICK;
          round_d    = '0;
          haveA_d    = 1'b0;
          scoreClear = 1'b1;
        end
      end
      PICK: begin
        if (candValid) begin
          if (!haveA_q) begin
            aSel_d  = candidate;
            haveA_d = 1'b1;
          end else if (candidate != aSel_q) begin
            bSel_d  = candidate;
            haveA_d = 1'b0;
            hitA_d  = 1'b0;
            hitB_d  = 1'b0;
            timer_d = '0;
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        timer_d = timer_q + TIMER_ONE;
        if (hitANow) hitA_d = 1'b1;
        if (hitBNow) hitB_d = 1'b1;
        if (((hitA_q || hitANow) && (hitB_q || hitBNow)) || (timer_q == TIMER_LAST)) begin
          state_d = END;
        end
      end
      END: begin
        round_d = round_q + 8'd1;
        state_d = (round_q == LAST_ROUND) ? GAME_OVER : PICK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      aSel_q      <= NO_TARGET;
      bSel_q      <= NO_TARGET;
      haveA_q     <= 1'b0;
      hitA_q      <= 1'b0;
      hitB_q      <= 1'b0;
      timer_q     <= '0;
      round_q     <= '0;
      laserLCnt_q <= '0;
      laserRCnt_q <= '0;
      debA_q      <= '0;
      debB_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      aSel_q      <= aSel_d;
      bSel_q      <= bSel_d;
      haveA_q     <= haveA_d;
      hitA_q      <= hitA_d;
      hitB_q      <= hitB_d;
      timer_q     <= timer_d;
      round_q     <= round_d;
      laserLCnt_q <= laserLCnt_d;
      laserRCnt_q <= laserRCnt_d;
      debA_q      <= debA_d;
      debB_q      <= debB_d;
    end
  end

  bcd_counter4 u_score (
    .clock   (clock),
    .reset   (reset),
    .clear_i (scoreClear),
    .add_i   (scoreAdd),
    .count_o (score_bcd)
  );

  assign laser_l   = inActive && (laserLCnt_q != '0);
  assign laser_r   = inActive && (laserRCnt_q != '0);
  assign target_a  = (inActive && !hitA_q) ? aSel_q : NO_TARGET;
  assign target_b  = (inActive && !hitB_q) ? bSel_q : NO_TARGET;
  assign round_num = round_q;
  assign game_over = (state_q == GAME_OVER);

endmodule
